// File: rtl/nn_pkg.sv
// ============================================================================
// nn_pkg: shared widths, sequencer state encoding and weight address helper
// Rev 1.0
// ============================================================================
`default_nettype none

package nn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } fetch_state_e;

  localparam int ADDR_CALC_W = 64;

  // Index widths never collapse to zero bits, even for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int layer_width(input int n_layers);
    return idx_width(n_layers);
  endfunction

  function automatic int unit_sel_width(input int n_units);
    return idx_width(n_units);
  endfunction

  function automatic int slot_width(input int wpu);
    return idx_width(wpu + 1);
  endfunction

  function automatic logic [ADDR_CALC_W-1:0] weight_addr(
    input logic [ADDR_CALC_W-1:0] base,
    input logic [ADDR_CALC_W-1:0] stride,
    input logic [ADDR_CALC_W-1:0] layer_idx,
    input logic [ADDR_CALC_W-1:0] unit_idx,
    input logic [ADDR_CALC_W-1:0] unit_words,
    input logic [ADDR_CALC_W-1:0] slot_idx
  );
    return base + layer_idx * stride + unit_idx * unit_words + slot_idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tag_delay_line.sv
// ============================================================================
// tag_delay_line: DEPTH-stage shift register of {valid, unit, slot} tags
// Rev 1.0
// ============================================================================
`default_nettype none

module tag_delay_line #(
  parameter int DEPTH  = 2,
  parameter int UNIT_W = 3,
  parameter int SLOT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [UNIT_W-1:0] in_unit,
  input  logic [SLOT_W-1:0] in_slot,
  output logic              out_valid,
  output logic [UNIT_W-1:0] out_unit,
  output logic [SLOT_W-1:0] out_slot,
  output logic              early_valid
);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [UNIT_W-1:0] unit_q [DEPTH];
  logic [UNIT_W-1:0] unit_d [DEPTH];
  logic [SLOT_W-1:0] slot_q [DEPTH];
  logic [SLOT_W-1:0] slot_d [DEPTH];

  // Invalid stages carry zero tags so the write-side outputs idle at 0.
  always_comb begin
    valid_d    = '0;
    valid_d[0] = in_valid;
    unit_d[0]  = in_valid ? in_unit : '0;
    slot_d[0]  = in_valid ? in_slot : '0;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      unit_d[i]  = unit_q[i-1];
      slot_d[i]  = slot_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        unit_q[i] <= '0;
        slot_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      unit_q  <= unit_d;
      slot_q  <= slot_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_unit  = unit_q[DEPTH-1];
  assign out_slot  = slot_q[DEPTH-1];

  generate
    if (DEPTH > 1) begin : g_early
      assign early_valid = |valid_q[DEPTH-2:0];
    end else begin : g_no_early
      assign early_valid = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/weight_fetch_sequencer.sv
// ============================================================================
// weight_fetch_sequencer: streams one layer's weights from RAM into the units;
// define WEIGHT_FETCH_BIAS_EN to fetch an extra bias word per unit. Rev 1.0
// ============================================================================
`default_nettype none

module weight_fetch_sequencer
  import nn_pkg::*;
#(
  parameter int ADDR_W           = 32,
  parameter int DATA_W           = 16,
  parameter int N_UNITS          = 8,
  parameter int WEIGHTS_PER_UNIT = 8,
  parameter int N_LAYERS         = 4,
  parameter int LAYER_BASE       = 0,
  parameter int LAYER_STRIDE     = 64,
  parameter int RD_LATENCY       = 2
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic [layer_width(N_LAYERS)-1:0]              layer,
  input  logic                                          hold,
  output logic [ADDR_W-1:0]                             RAM_address,
  output logic                                          ram_rd_en,
  input  logic [DATA_W-1:0]                             ram_rd_data,
  output logic [unit_sel_width(N_UNITS)-1:0]            unit_sel,
  output logic [slot_width(WEIGHTS_PER_UNIT)-1:0]       unit_address,
  output logic [DATA_W-1:0]                             unit_data,
  output logic                                          write,
  output logic                                          sum_trigger,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          err
);

  localparam int LAYER_W = layer_width(N_LAYERS);
  localparam int UNIT_W  = unit_sel_width(N_UNITS);
  localparam int SLOT_W  = slot_width(WEIGHTS_PER_UNIT);
`ifdef WEIGHT_FETCH_BIAS_EN
  localparam int UNIT_WORDS = WEIGHTS_PER_UNIT + 1;
`else
  localparam int UNIT_WORDS = WEIGHTS_PER_UNIT;
`endif
  localparam logic [UNIT_W-1:0] LAST_UNIT = UNIT_W'(N_UNITS - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(UNIT_WORDS - 1);

  fetch_state_e       state_q, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [UNIT_W-1:0]  unit_q, unit_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               issue_fire;
  logic               tag_valid;
  logic [UNIT_W-1:0]  tag_unit;
  logic [SLOT_W-1:0]  tag_slot;
  logic               tag_early_valid;
  logic [ADDR_W-1:0]  addr_calc;

  assign issue_fire = (state_q == ST_ISSUE) && !hold;

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    unit_d  = unit_q;
    slot_d  = slot_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (32'(layer) < N_LAYERS) begin
            state_d = ST_ISSUE;
            layer_d = layer;
            unit_d  = '0;
            slot_d  = '0;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (issue_fire) begin
          if (unit_q == LAST_UNIT && slot_q == LAST_SLOT) begin
            state_d = ST_DRAIN;
          end else if (slot_q == LAST_SLOT) begin
            slot_d = '0;
            unit_d = unit_q + UNIT_W'(1);
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end
      // Only the final stage may still hold a tag: it retires this cycle.
      ST_DRAIN: begin
        if (!tag_early_valid) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      layer_q <= '0;
      unit_q  <= '0;
      slot_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      unit_q  <= unit_d;
      slot_q  <= slot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign addr_calc = ADDR_W'(weight_addr(ADDR_CALC_W'(LAYER_BASE), ADDR_CALC_W'(LAYER_STRIDE),
                                         ADDR_CALC_W'(layer_q), ADDR_CALC_W'(unit_q),
                                         ADDR_CALC_W'(UNIT_WORDS), ADDR_CALC_W'(slot_q)));

  assign ram_rd_en   = issue_fire;
  assign RAM_address = issue_fire ? addr_calc : '0;

  tag_delay_line #(
    .DEPTH  (RD_LATENCY),
    .UNIT_W (UNIT_W),
    .SLOT_W (SLOT_W)
  ) u_tag_delay_line (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (issue_fire),
    .in_unit     (unit_q),
    .in_slot     (slot_q),
    .out_valid   (tag_valid),
    .out_unit    (tag_unit),
    .out_slot    (tag_slot),
    .early_valid (tag_early_valid)
  );

  assign write        = tag_valid;
  assign unit_sel     = tag_unit;
  assign unit_address = tag_slot;
  assign unit_data    = tag_valid ? ram_rd_data : '0;

  assign sum_trigger = done_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

`default_nettype wire

// File: doc/weight_fetch_sequencer.md
# weight_fetch_sequencer

Parametrised successor to the layer RAM read driver. On `start`, it streams every weight of one network layer from the weight RAM into the neuron units. It issues one RAM read per cycle, re-aligns each returned word with its unit/slot tag across a configurable RAM read latency, and writes it into the addressed unit. After the last write it pulses `sum_trigger` to launch the units' accumulate step. It sits between the top-level layer controller and the neuron unit array.

## Interface
- `ADDR_W`, 32, RAM address width
- `DATA_W`, 16, weight word width
- `N_UNITS`, 8, neuron units per layer (≥1)
- `WEIGHTS_PER_UNIT`, 8, weight slots per unit (≥1)
- `N_LAYERS`, 4, legal layer count
- `LAYER_BASE`, 0, RAM address of layer 0 word 0
- `LAYER_STRIDE`, 64, address distance between layers
- `RD_LATENCY`, 2, cycles from `ram_rd_en` to valid `ram_rd_data` (≥1)

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle request, sampled only in IDLE
- `layer` in clog2(N_LAYERS): layer index, captured with `start`
- `hold` in 1: suspends read issue while high
- `RAM_address` out ADDR_W: read address
- `ram_rd_en` out 1: read strobe
- `ram_rd_data` in DATA_W: read data, RD_LATENCY after strobe
- `unit_sel` out clog2(N_UNITS): destination unit
- `unit_address` out clog2(WPU+1): slot within unit
- `unit_data` out DATA_W: word to write
- `write` out 1: unit write strobe
- `sum_trigger` out 1: one-cycle pulse after the last write
- `busy` out 1: high from the cycle after `start` until `done`
- `done` out 1: one-cycle pulse, coincident with `sum_trigger`
- `err` out 1: one-cycle pulse on an illegal layer

## Operation
- States: IDLE, ISSUE, DRAIN, FINISH.
- IDLE:
  - `start`=1 with `layer` < N_LAYERS → ISSUE. Capture `layer` and clear the unit and slot counters.
  - `start`=1 with `layer` ≥ N_LAYERS → `err` pulse, stay in IDLE, no reads issued.
- ISSUE:
  - Each cycle with `hold`=0: `ram_rd_en`=1, `RAM_address` = LAYER_BASE + layer·LAYER_STRIDE + unit·WPU + slot, computed modulo 2^ADDR_W.
  - Advance the slot counter; when it wraps, advance the unit counter.
  - Order is unit-major: unit 0 slots 0..WPU-1, then unit 1, and so on.
  - `hold`=1: `ram_rd_en`=0, counters frozen. In-flight reads still complete.
  - After the last read is issued → DRAIN.
- Tag pipeline: {unit, slot} delayed RD_LATENCY cycles, alongside a valid bit. When valid: `write`=1, `unit_data`=`ram_rd_data`, tag driven on `unit_sel`/`unit_address`. Units always accept writes.
- DRAIN: wait until the pipeline is empty, then → FINISH.
- FINISH: `sum_trigger`=1, `done`=1 for one cycle → IDLE.
- `start` while not in IDLE is ignored.
- `reset` low at any time:
  - All state is cleared and in-flight tags are discarded.
  - All outputs are 0; `RAM_address`, `unit_sel`, `unit_address` and `unit_data` also reset to 0.

## Timing
- `start` sampled at cycle 0.
- First read at cycle 1; its `write` at cycle 1+RD_LATENCY.
- With no hold, read k issues at cycle k+1, where total reads R = N_UNITS·WPU.
- Last write at cycle R+RD_LATENCY; `sum_trigger`/`done` at R+RD_LATENCY+1; IDLE (`busy`=0) at R+RD_LATENCY+2.
- Each hold cycle adds exactly one cycle to the end-of-layer timing.
- `err` is asserted at cycle 1; `busy` stays 0.
- A `start` on the cycle after `done` is accepted.

## Configuration
- `WEIGHT_FETCH_BIAS_EN` defined:
  - Each unit gets one extra word at slot WPU (its bias).
  - Per-unit word count becomes WPU+1; the address formula uses WPU+1 for the unit stride.
  - R = N_UNITS·(WPU+1).
- Not defined: exactly WPU words per unit; slot WPU is never driven.
- `unit_address` is clog2(WPU+1) wide in both builds.

## Structure
- Shared package `nn_pkg`:
  - Layer-index and unit-select widths.
  - State enum encoding.
  - Address-computation function.
- One sub-module, `tag_delay_line`: a RD_LATENCY-deep shift register of {valid, unit, slot}, with async active-low clear.

## Test plan
Defaults: N_UNITS=8, WPU=8, RD_LATENCY=2, LAYER_STRIDE=64, LAYER_BASE=0; macro off unless stated.
- Reset, then `start` with layer=0 → reads at addresses 0..63 in cycles 1..64; `write` in cycles 3..66; `unit_sel` steps every 8 writes; `unit_data` equals the RAM model; `sum_trigger`/`done` at cycle 67.
- layer=2 → addresses 128..191; `sum_trigger` at cycle 67.
- `hold` high in cycles 10–14 → no `ram_rd_en` in those cycles; tags still match the data; `sum_trigger` at cycle 72.
- layer=3 with N_LAYERS=3 → `err` at cycle 1; no `ram_rd_en`; `busy` stays 0.
- `reset` low at cycle 20 → all outputs 0 immediately; after release, a new `start` restarts at address 0 with no stale writes; `start` pulsed at cycle 30 of that run is ignored.
- Macro on → 72 reads; slot 8 is written for every unit; `sum_trigger` at cycle 75.
